// File: rtl/riscv_isa_pkg.sv
// Shared RISC-V M-extension definitions: op encodings and the control bundle
// used by both the multiplier/divider top and the sequential divider.
package riscv_isa_pkg;

    typedef enum logic [1:0] {
        M_MUL = 2'b00,
        M_MUH = 2'b01,
        M_DIV = 2'b10,
        M_REM = 2'b11
    } op_m_t;

    typedef struct packed {
        op_m_t op;
        logic  s1;
        logic  s2;
    } ctl_m_t;

    // The divider only understands DIV/REM with matching operand signedness.
    function automatic logic ctl_m_div_legal(input ctl_m_t c);
        return ((c.op == M_DIV) || (c.op == M_REM)) && (c.s1 == c.s2);
    endfunction

endpackage

// File: rtl/r5p_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with
// early completion for divide-by-zero and signed overflow.
module r5p_div_seq
    import riscv_isa_pkg::*;
#(
    parameter int unsigned XW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_vld,
    output logic          req_rdy,
    input  ctl_m_t        ctl,
    input  logic [XW-1:0] rs1,
    input  logic [XW-1:0] rs2,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic [XW-1:0] rd
);

    localparam int unsigned CW = $clog2(XW) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // quo_q starts as the dividend magnitude and fills with quotient bits.
    logic [XW-1:0] quo_q, quo_d;
    logic [XW-1:0] rem_q, rem_d;
    logic [XW-1:0] div_q, div_d;
    op_m_t         op_q, op_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;

    logic [XW:0]   rem_shift;
    logic          step_ge;
    logic [XW-1:0] step_rem;
    logic [XW-1:0] step_quo;
    logic          sgn;
    logic          a_neg;
    logic          b_neg;

    assign rem_shift = {rem_q, quo_q[XW-1]};
    assign step_ge   = rem_shift >= {1'b0, div_q};
    // The true difference is always below the divisor, so XW bits suffice.
    assign step_rem  = step_ge ? (rem_shift[XW-1:0] - div_q) : rem_shift[XW-1:0];
    assign step_quo  = {quo_q[XW-2:0], step_ge};

    assign sgn   = ctl.s1 & ctl.s2;
    assign a_neg = sgn & rs1[XW-1];
    assign b_neg = sgn & rs2[XW-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_d     = div_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    op_d      = ctl.op;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    if (rs2 == '0) begin
                        quo_d   = '1;
                        rem_d   = rs1;
                        state_d = ST_DONE;
                    end else if (sgn && (rs1 == {1'b1, {(XW-1){1'b0}}}) && (rs2 == '1)) begin
                        quo_d   = rs1;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        quo_d   = a_neg ? -rs1 : rs1;
                        div_d   = b_neg ? -rs2 : rs2;
                        rem_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XW - 1)) begin
                    quo_d   = neg_quo_q ? -step_quo : step_quo;
                    rem_d   = neg_rem_q ? -step_rem : step_rem;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            op_q      <= M_MUL;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign req_rdy = (state_q == ST_IDLE);
    assign rsp_vld = (state_q == ST_DONE);
    assign rd      = (op_q == M_DIV) ? quo_q : rem_q;

    a_ctl_legal: assert property (@(posedge clk) disable iff (rst)
        (req_vld && req_rdy) |-> ctl_m_div_legal(ctl));

endmodule

// File: tb/tb_r5p_div_seq.sv
// Directed-vector bench for r5p_div_seq: results, latency, backpressure and
// reset abort against hand-computed expectations.
module tb_r5p_div_seq;
    import riscv_isa_pkg::*;

    localparam int XW = 32;

    logic          clk;
    logic          rst;
    logic          req_vld;
    logic          req_rdy;
    ctl_m_t        ctl;
    logic [XW-1:0] rs1;
    logic [XW-1:0] rs2;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [XW-1:0] rd;

    int n_checks = 0;
    int n_errors = 0;

    r5p_div_seq #(.XW(XW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .ctl     (ctl),
        .rs1     (rs1),
        .rs2     (rs2),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rd      (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge, then scramble the inputs (keeping
    // req_vld high) until the response shows up; returns at that negedge.
    task automatic do_op(input string tag, input op_m_t op, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        check({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
        ctl.op  = op;
        ctl.s1  = sg;
        ctl.s2  = sg;
        rs1     = a;
        rs2     = b;
        req_vld = 1'b1;
        @(posedge clk);
        #1;
        rs1    = $urandom;
        rs2    = $urandom;
        ctl.op = (op == M_DIV) ? M_REM : M_DIV;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (rsp_vld) begin
                lat = n;
                break;
            end
        end
        req_vld = 1'b0;
        check({tag, "_rd"}, rd, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        $display("op %s a=0x%08h b=0x%08h rd=0x%08h lat=%0d", tag, a, b, rd, lat);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_rdy = 1'b1;
        @(negedge clk);
        check({tag, "_idle_rdy"}, 32'(req_rdy), 32'd1);
        check({tag, "_idle_vld"}, 32'(rsp_vld), 32'd0);
    endtask

    initial begin
        int seen;
        rst     = 1'b1;
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        ctl.op  = M_DIV;
        ctl.s1  = 1'b0;
        ctl.s2  = 1'b0;
        rs1     = 32'd9;
        rs2     = 32'd3;
        repeat (3) @(negedge clk);
        // A request during reset must not be taken.
        req_vld = 1'b1;
        @(negedge clk);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rd", rd, 32'd0);
        rst     = 1'b0;
        req_vld = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 32'(req_rdy), 32'd1);

        do_op("udiv_100_7", M_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 33);
        finish_rsp("udiv_100_7");
        do_op("urem_100_7", M_REM, 1'b0, 32'd100, 32'd7, 32'd2, 33);
        finish_rsp("urem_100_7");
        do_op("sdiv_m7_2", M_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        finish_rsp("sdiv_m7_2");
        do_op("srem_m7_2", M_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        finish_rsp("srem_m7_2");
        do_op("sdiv_7_m2", M_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        finish_rsp("sdiv_7_m2");
        do_op("srem_7_m2", M_REM, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        finish_rsp("srem_7_m2");
        do_op("sdiv_m8_m3", M_DIV, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 33);
        finish_rsp("sdiv_m8_m3");
        do_op("srem_m8_m3", M_REM, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33);
        finish_rsp("srem_m8_m3");
        do_op("udiv_max_1", M_DIV, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        finish_rsp("udiv_max_1");
        do_op("udiv_min_max", M_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        finish_rsp("udiv_min_max");
        do_op("urem_min_max", M_REM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        finish_rsp("urem_min_max");

        do_op("udiv_5_0", M_DIV, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        finish_rsp("udiv_5_0");
        do_op("urem_5_0", M_REM, 1'b0, 32'd5, 32'd0, 32'd5, 1);
        finish_rsp("urem_5_0");
        do_op("sdiv_5_0", M_DIV, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        finish_rsp("sdiv_5_0");
        do_op("srem_5_0", M_REM, 1'b1, 32'd5, 32'd0, 32'd5, 1);
        finish_rsp("srem_5_0");
        do_op("sdiv_ovf", M_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        finish_rsp("sdiv_ovf");
        do_op("srem_ovf", M_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        finish_rsp("srem_ovf");

        // Backpressure: result must hold while a competing request waits.
        rsp_rdy = 1'b0;
        do_op("bp_udiv", M_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 33);
        ctl.op  = M_REM;
        rs1     = 32'd9;
        rs2     = 32'd4;
        req_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rd", rd, 32'd14);
            check("bp_rsp_vld", 32'(rsp_vld), 32'd1);
            check("bp_req_rdy", 32'(req_rdy), 32'd0);
        end
        req_vld = 1'b0;
        finish_rsp("bp_release");

        // Reset in the middle of CALC discards the operation.
        ctl.op  = M_DIV;
        ctl.s1  = 1'b0;
        ctl.s2  = 1'b0;
        rs1     = 32'd100;
        rs2     = 32'd7;
        req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_in_calc", 32'(req_rdy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rsp_vld", 32'(rsp_vld), 32'd0);
        check("abort_req_rdy", 32'(req_rdy), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_vld) seen++;
        end
        check("abort_never_vld", 32'(seen), 32'd0);
        check("abort_rd_clear", rd, 32'd0);

        do_op("after_abort", M_REM, 1'b0, 32'd1000, 32'd33, 32'd10, 33);
        finish_rsp("after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/r5p_div_seq.md
R5P_DIV_SEQ -- requirements
Module: r5p_div_seq

Interface
REQ-001 The block SHALL have parameter XW, default 32, meaning the data width in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req_vld  input  1  request valid from the issue stage.
REQ-005 The block SHALL have port req_rdy  output  1  the block can accept a request.
REQ-006 The block SHALL have port ctl  input  ctl_m_t  M-extension control (op, s1, s2), sampled on request acceptance.
REQ-007 The block SHALL have port rs1  input  XW  dividend, sampled on request acceptance.
REQ-008 The block SHALL have port rs2  input  XW  divisor, sampled on request acceptance.
REQ-009 The block SHALL have port rsp_vld  output  1  result valid towards writeback.
REQ-010 The block SHALL have port rsp_rdy  input  1  writeback accepts the result.
REQ-011 The block SHALL have port rd  output  XW  quotient (M_DIV) or remainder (M_REM).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 req_rdy SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where req_vld=1 and req_rdy=1.
REQ-014 Only ctl.op values M_DIV and M_REM SHALL be legal; {s1,s2} SHALL be {0,0} (unsigned) or {1,1} (signed); other combinations are illegal and SHALL trip a simulation assertion.
REQ-015 On acceptance, if rs2=0, the FSM SHALL go IDLE->DONE with quotient=all ones and remainder=rs1.
REQ-016 On acceptance, for a signed request with rs1=most-negative and rs2=all ones, the FSM SHALL go IDLE->DONE with quotient=rs1 and remainder=0.
REQ-017 Otherwise, on acceptance, the FSM SHALL go IDLE->CALC, load the operand magnitudes (absolute values when signed), and clear the partial remainder and the iteration counter.
REQ-018 CALC SHALL perform one restoring-division step per cycle, producing one quotient bit MSB-first, for exactly XW cycles; the counter SHALL be $clog2(XW)+1 bits wide and SHALL not wrap.
REQ-019 After the last step the FSM SHALL go CALC->DONE; the quotient SHALL be negated when the operand signs differ (signed only), and the remainder SHALL take the dividend's sign.
REQ-020 Latency from the acceptance edge to rsp_vld=1 SHALL be XW+1 cycles in the normal case and 1 cycle in the special cases (REQ-015, REQ-016).
REQ-021 rsp_vld SHALL be 1 only in DONE; rd SHALL be the registered result selected by the latched op.
REQ-022 rd SHALL hold stable while rsp_vld=1 and rsp_rdy=0.
REQ-023 On a rising edge in DONE with rsp_rdy=1 the FSM SHALL return to IDLE; a new request SHALL be accepted no earlier than the following edge (no bypass).
REQ-024 req_vld and input changes during CALC or DONE SHALL be ignored.
REQ-025 rs1, rs2 and ctl SHALL be captured into registers at acceptance; the result SHALL not depend on their later values.

Reset
REQ-026 While rst=1 at a rising edge the state SHALL become IDLE, req_rdy=1, rsp_vld=0, rd=0, and the counter and datapath registers SHALL be cleared.
REQ-027 Reset asserted in CALC or DONE SHALL abort the operation; the result SHALL be discarded and never presented.
REQ-028 A request presented in the same cycle as rst=1 SHALL not be accepted.

Structure
REQ-029 ctl_m_t and the M_MUL/M_MUH/M_DIV/M_REM op encodings SHALL come from riscv_isa_pkg, shared with r5p_muldiv.
REQ-030 The FSM state enum SHALL be local to the module.
REQ-031 The block SHALL contain no sub-module; the datapath SHALL be the XW+1-bit subtract/compare, a shift register and sign fixup.

Verification
REQ-032 Scenario: unsigned M_DIV 100/7 -> rd=14 with rsp_vld rising exactly 33 cycles after the accepting edge; M_REM 100/7 -> rd=2.
REQ-033 Scenario: signed -7/2 -> M_DIV rd=0xFFFFFFFD and M_REM rd=0xFFFFFFFF.
REQ-034 Scenario: 5/0, unsigned and signed -> M_DIV rd=0xFFFFFFFF and M_REM rd=5, with rsp_vld 1 cycle after acceptance.
REQ-035 Scenario: signed 0x80000000/0xFFFFFFFF -> M_DIV rd=0x80000000 and M_REM rd=0, with 1-cycle latency.
REQ-036 Scenario: rsp_rdy held 0 for 5 cycles in DONE -> rd and rsp_vld stable, req_rdy=0, and no new request accepted even with req_vld=1.
REQ-037 Scenario: rst pulsed 1 cycle at CALC cycle 10 -> next cycle rsp_vld=0 and req_rdy=1, and the aborted result never appears.
